// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master transfer engine:
//   - spi_state_e : transfer FSM states (IDLE, XFER, TRAIL, DONE)
//   - MODE_RUN / MODE_WAIT : spi_mode encodings (1x = stop)
//   - SPI_DATA_W / SPI_CNT_W : default frame and baud counter widths
//   - spi_divisor() : baud divisor (sppr+1) * 2^(spr+1), range 2..2048
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_CNT_W  = 12;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_WAIT = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    XFER  = 2'b01,
    TRAIL = 2'b10,
    DONE  = 2'b11
  } spi_state_e;

  // Full SCLK period in PCLK cycles; the largest value (2048) still fits 12 bits.
  function automatic logic [11:0] spi_divisor(input logic [2:0] sppr, input logic [2:0] spr);
    logic [11:0] base;
    base = {9'd0, sppr} + 12'd1;
    return base << ({1'b0, spr} + 4'd1);
  endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// -----------------------------------------------------------------------------
// spi_baud_gen
// Half-period timer for SCLK. The half-period is captured on load and held for
// the whole frame, so later register writes cannot disturb a running transfer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture half_cnt and clear the counter (transfer start)
//   half_cnt   : half-period in clock cycles (>= 1)
//   run        : counter active (XFER/TRAIL); counter held at 0 otherwise
//   freeze     : hold the counter where it is (wait/stop mode)
//   edge_stb   : one-cycle strobe at the last cycle of each half-period
// -----------------------------------------------------------------------------
module spi_baud_gen
  import spi_pkg::*;
#(
  parameter int CNT_W = SPI_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] half_cnt,
  input  logic             run,
  input  logic             freeze,
  output logic             edge_stb
);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end   = (cnt_q == (half_q - CNT_W'(1)));
  assign edge_stb = run & ~freeze & at_end;

  // Next-state logic for the latched half-period and the running counter.
  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    if (load) begin
      half_d = half_cnt;
      cnt_d  = '0;
    end else if (!run) begin
      cnt_d = '0;
    end else if (freeze) begin
      cnt_d = cnt_q;
    end else if (at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and divisor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= CNT_W'(1);
      cnt_q  <= '0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
// SPI master transfer engine: generates SCLK/SS, shifts one frame out on MOSI
// while capturing MISO, and reports completion to the APB interface stage.
// Ports:
//   PCLK, PRESET       : clock, asynchronous active-high reset
//   mstr, cpol, cpha, lsbfe, spiswai, spi_mode, sppr, spr : register file
//   send_data, tx_data : one-cycle start request with the frame to send
//   miso               : serial input
//   sclk, mosi, ss     : serial clock, serial output, active-low select
//   tip                : transfer in progress
//   receive_data       : one-cycle frame-complete pulse
//   miso_data          : last fully received frame
// -----------------------------------------------------------------------------
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int CNT_W  = SPI_CNT_W
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              mstr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              spiswai,
  input  logic [1:0]        spi_mode,
  input  logic [2:0]        sppr,
  input  logic [2:0]        spr,
  input  logic              send_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              tip,
  output logic              receive_data,
  output logic [DATA_W-1:0] miso_data
);

  localparam int              EC_W      = $clog2(2 * DATA_W + 1);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] miso_data_q, miso_data_d;
  logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic              rx_bit_q, rx_bit_d;
  logic              mosi_q, mosi_d;
  logic              ss_q, ss_d;
  logic              tip_q, tip_d;
  logic              rcv_q, rcv_d;
  logic              tog_q, tog_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsbfe_q, lsbfe_d;

  logic              start;
  logic              freeze;
  logic              busy;
  logic              edge_stb;
  logic [EC_W-1:0]   edge_num;
  logic [CNT_W-1:0]  half_cnt;

  // Bit currently presented on MOSI for the given order.
  function automatic logic pick_out(input logic [DATA_W-1:0] sh, input logic lsb);
    return lsb ? sh[0] : sh[DATA_W-1];
  endfunction

  // Advance the frame by one bit, inserting the received bit at the far end.
  function automatic logic [DATA_W-1:0] shift_frame(input logic [DATA_W-1:0] sh,
                                                    input logic lsb, input logic in_bit);
    return lsb ? {in_bit, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], in_bit};
  endfunction

  assign start    = (state_q == IDLE) && send_data && mstr && (spi_mode == MODE_RUN);
  assign freeze   = ((spi_mode == MODE_WAIT) && spiswai) || spi_mode[1];
  assign busy     = (state_q == XFER) || (state_q == TRAIL);
  assign edge_num = edge_cnt_q + EC_W'(1);
  assign half_cnt = CNT_W'(spi_divisor(sppr, spr) >> 1);

  spi_baud_gen #(.CNT_W(CNT_W)) u_baud (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     (start),
    .half_cnt (half_cnt),
    .run      (busy),
    .freeze   (freeze),
    .edge_stb (edge_stb)
  );

  // Transfer FSM: next state, shift register and output register updates.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    miso_data_d = miso_data_q;
    edge_cnt_d  = edge_cnt_q;
    rx_bit_d    = rx_bit_q;
    mosi_d      = mosi_q;
    ss_d        = ss_q;
    tip_d       = tip_q;
    rcv_d       = 1'b0;
    tog_d       = tog_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsbfe_d     = lsbfe_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = XFER;
          shreg_d    = tx_data;
          ss_d       = 1'b0;
          tip_d      = 1'b1;
          edge_cnt_d = '0;
          tog_d      = 1'b0;
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsbfe_d    = lsbfe;
          // With cpha=0 the first bit must be valid as soon as ss falls.
          mosi_d     = pick_out(tx_data, lsbfe);
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!mstr) begin
          state_d = IDLE;
          ss_d    = 1'b1;
          tip_d   = 1'b0;
        end else if (edge_stb) begin
          tog_d      = ~tog_q;
          edge_cnt_d = edge_num;
          if (edge_num[0]) begin
            // Leading edge: cpha=1 drives the next bit, cpha=0 samples MISO.
            if (cpha_q) begin
              mosi_d = pick_out(shreg_q, lsbfe_q);
            end else begin
              rx_bit_d = miso;
            end
          end else begin
            // Trailing edge: the frame shifts in both phases; cpha=0 takes the
            // bit sampled on the leading edge, cpha=1 samples MISO right now.
            shreg_d = shift_frame(shreg_q, lsbfe_q, cpha_q ? miso : rx_bit_q);
            // Last edge only completes the receive; MOSI keeps the final bit.
            if (!cpha_q && (edge_num != LAST_EDGE)) begin
              mosi_d = pick_out(shreg_d, lsbfe_q);
            end else begin
              mosi_d = mosi_q;
            end
          end
          if (edge_num == LAST_EDGE) begin
            state_d = TRAIL;
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = XFER;
        end
      end
      TRAIL: begin
        if (!mstr) begin
          state_d = IDLE;
          ss_d    = 1'b1;
          tip_d   = 1'b0;
        end else if (edge_stb) begin
          state_d     = DONE;
          ss_d        = 1'b1;
          tip_d       = 1'b0;
          rcv_d       = 1'b1;
          miso_data_d = shreg_q;
        end else begin
          state_d = TRAIL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      miso_data_q <= '0;
      edge_cnt_q  <= '0;
      rx_bit_q    <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      tip_q       <= 1'b0;
      rcv_q       <= 1'b0;
      tog_q       <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      miso_data_q <= miso_data_d;
      edge_cnt_q  <= edge_cnt_d;
      rx_bit_q    <= rx_bit_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      tip_q       <= tip_d;
      rcv_q       <= rcv_d;
      tog_q       <= tog_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsbfe_q     <= lsbfe_d;
    end
  end

  // In IDLE the idle level follows the live cpol register; during a frame the
  // latched polarity is used so a mid-frame write cannot glitch SCLK.
  assign sclk         = (state_q == IDLE) ? cpol : (cpol_q ^ tog_q);
  assign mosi         = mosi_q;
  assign ss           = ss_q;
  assign tip          = tip_q;
  assign receive_data = rcv_q;
  assign miso_data    = miso_data_q;

endmodule
